// File: rtl/mux_nx1_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_rr_if
// Brief    : Producer/consumer handshake bundle for the N:1 round-robin mux.
//            Packet lock ports exist only when MUX_PKT_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_nx1_rr_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_src;
`ifdef MUX_PKT_LOCK_EN
    logic [N-1:0]       in_last;
    logic               out_last;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_src, out_last
    );
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_src, out_last
    );
`else
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mux_nx1_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_rr
// Brief    : N:1 registered mux with valid/ready on every channel, fixed or
//            round-robin selection. MUX_PKT_LOCK_EN adds packet locking.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nx1_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            mode,
    input  wire logic [SELW-1:0] sel,
    mux_nx1_rr_if.slave          bus
);
    localparam int c_NPOW = 1 << SELW;

    // Channels padded to 2**SELW entries so any SELW-bit index is in range.
    wire [WIDTH-1:0]  ch_data [c_NPOW];
    wire [c_NPOW-1:0] valid_pad;
`ifdef MUX_PKT_LOCK_EN
    wire [c_NPOW-1:0] last_pad;
`endif

    for (genvar i = 0; i < c_NPOW; i++) begin : g_ch
        if (i < N) begin : g_used
            assign ch_data[i]   = bus.in_data[i*WIDTH +: WIDTH];
            assign valid_pad[i] = bus.in_valid[i];
`ifdef MUX_PKT_LOCK_EN
            assign last_pad[i]  = bus.in_last[i];
`endif
        end else begin : g_pad
            assign ch_data[i]   = '0;
            assign valid_pad[i] = 1'b0;
`ifdef MUX_PKT_LOCK_EN
            assign last_pad[i]  = 1'b0;
`endif
        end
    end

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SELW-1:0]   out_src_q, out_src_d;
    logic              out_valid_q, out_valid_d;
    logic [SELW-1:0]   last_q, last_d;

    logic              lock_act;
    logic [SELW-1:0]   lock_ch;
`ifdef MUX_PKT_LOCK_EN
    logic              lock_q, lock_d;
    logic [SELW-1:0]   lock_ch_q, lock_ch_d;
    logic              out_last_q, out_last_d;
    assign lock_act = lock_q;
    assign lock_ch  = lock_ch_q;
`else
    assign lock_act = 1'b0;
    assign lock_ch  = '0;
`endif

    logic              load;
    logic              rr_vld;
    logic [SELW-1:0]   rr_idx;
    logic              grant_vld;
    logic [SELW-1:0]   grant_idx;
    logic              xfer;
    logic [c_NPOW-1:0] ready_pad;

    // Walk from farthest to nearest so the channel right after last wins.
    always_comb begin : p_rr_search
        int idx;
        rr_vld = 1'b0;
        rr_idx = '0;
        idx    = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (valid_pad[SELW'(idx)]) begin
                rr_vld = 1'b1;
                rr_idx = SELW'(idx);
            end
        end
    end

    always_comb begin : p_grant
        grant_vld = 1'b0;
        grant_idx = '0;
        if (lock_act) begin
            grant_vld = valid_pad[lock_ch];
            grant_idx = lock_ch;
        end else if (mode) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end else begin
            grant_vld = (int'(sel) < N) && valid_pad[sel];
            grant_idx = sel;
        end
    end

    assign load = !out_valid_q || bus.out_ready;
    assign xfer = load && grant_vld && !rst;

    always_comb begin : p_ready
        ready_pad = '0;
        if (xfer) begin
            ready_pad[grant_idx] = 1'b1;
        end
    end

    assign bus.in_ready = ready_pad[N-1:0];

    always_comb begin : p_next
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = ch_data[grant_idx];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                last_d = grant_idx;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_comb begin : p_lock_next
        lock_d     = lock_q;
        lock_ch_d  = lock_ch_q;
        out_last_d = out_last_q;
        if (xfer) begin
            lock_d     = !last_pad[grant_idx];
            lock_ch_d  = grant_idx;
            out_last_d = last_pad[grant_idx];
        end
    end

    always_ff @(posedge clk) begin : p_lock_regs
        if (rst) begin
            lock_q     <= 1'b0;
            lock_ch_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_ch_q  <= lock_ch_d;
            out_last_q <= out_last_d;
        end
    end

    assign bus.out_last = out_last_q;
`endif

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with a registered output stage and valid/ready handshaking on every input and on the output.
- It is the sequential successor of the 2:1 mux cell.
- Two select modes:
  - Fixed: an external select index chooses the source.
  - Round-robin: internal fair arbitration among valid sources.
- Sits between several producer channels and a single consumer, for example merging sensor or FIFO streams onto one bus.

Parameters:
- WIDTH, 8, data bits per channel
- N, 4, number of input channels (2..16)
- SELW, 2, select/index width; must satisfy 2**SELW >= N

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = fixed select via sel; 1 = round-robin
- sel  input  SELW  source index used when mode=0
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (one-hot or zero)
- out_data  output  WIDTH  registered output data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat
- out_src  output  SELW  index of the channel that produced out_data

Behaviour:
- Reset: synchronous and active-high; clk and rst as named above. While rst=1 at a rising edge:
  - out_valid=0, out_data=0, out_src=0.
  - RR pointer last=N-1, so the first round-robin search starts at channel 0.
  - in_ready is 0 while rst is high.
- load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Grant selection is combinational from the current inputs:
  - mode=0: grant = sel if sel<N and in_valid[sel]=1; otherwise no grant. sel>=N never grants.
  - mode=1: grant = first i with in_valid[i]=1, searching last+1, last+2, ... modulo N (wrap N-1 -> 0). No valid inputs means no grant.
- in_ready[g] = load && grant exists && g==grant. All other in_ready bits are 0. in_ready never depends on in_valid of any non-granted channel.
- Transfer in (in_valid[g] && in_ready[g]):
  - At the next edge: out_data <= channel g data, out_src <= g, out_valid <= 1.
  - In mode=1, last <= g.
- Output handshake:
  - If out_ready=1 and no new grant, out_valid <= 0 at the next edge. out_data and out_src hold their last values.
  - If out_valid=1 and out_ready=0, out_data and out_src stay stable and all in_ready are 0 (backpressure).
- Latency: 1 cycle from input acceptance to out_valid. Sustained throughput is 1 beat/cycle when out_ready is held at 1.
- Simultaneous output drain and new acceptance in the same cycle is allowed; there is no bubble.
- Mode change: takes effect on the next grant evaluation. last is preserved across mode changes and updates only on mode=1 transfers.
- Reset mid-operation: any beat in the output register is discarded and last returns to N-1.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- When defined:
  - Adds input in_last[N] and output out_last (registered alongside out_data).
  - After a granted transfer with in_last[g]=0, the grant is locked to g, in both modes, until a transfer from g with in_last[g]=1 completes.
  - While locked, sel and other valid channels are ignored.
  - Reset clears the lock and sets out_last=0.
- When undefined: the ports are absent and arbitration is re-evaluated every beat.

Test Plan:
- Reset, then N=4, mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100, and the next cycle out_valid=1, out_data=A5, out_src=2.
- mode=1, all in_valid=1111, ch0..3=10,11,12,13, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,3,0,1 with one beat per cycle.
- mode=1, in_valid=1010, last=3 after reset with one prior ch3 beat -> grants alternate 1,3,1,3; channels 0 and 2 never see in_ready=1.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data stable, in_ready=0000. Then out_ready=1 with a pending valid -> drain and refill in the same cycle with no bubble.
- mode=0, sel=3'd5 with N=4 (SELW=3) -> no in_ready and out_valid stays 0. Assert rst mid-stream with out_valid=1 -> the next cycle out_valid=0, and a following mode=1 grant starts at ch0.
- With MUX_PKT_LOCK_EN: ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 stay valid in mode=1 -> out_src=1,1,1, then 2, with out_last=0,0,1,0.
